uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter START_TIMEOUT, default 16, max cycles to wait for tx_busy rise after tx_start.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  level per requester; byte pending.
REQ-006 req_data  input  8*N_REQ  flat bytes; requester i at bits [8i+7:8i].
REQ-007 ack  output  N_REQ  one-cycle pulse; requester i's byte captured.
REQ-008 tx_start  output  1  one-cycle start pulse to the shared uart2 transmitter.
REQ-009 tx_data  output  8  registered byte to uart2 tx_data; stable from START until IDLE.
REQ-010 tx_busy  input  1  uart2 transmitter busy.
REQ-011 grant_id  output  clog2(N_REQ)  index of last granted requester.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 err_timeout  output  1  one-cycle pulse; tx_busy never rose after tx_start.

Function
REQ-014 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE; state registered.
REQ-015 IDLE: grant only if any req=1 and tx_busy=0; otherwise hold IDLE.
REQ-016 Round-robin: search starts at (ptr+1) mod N_REQ, first set req wins; ptr and grant_id load the winner index on grant.
REQ-017 On grant edge: tx_data <= winner's byte, ack[winner] high for the following cycle only, state -> START.
REQ-018 START: tx_start=1 for exactly that cycle; -> WAIT_BUSY.
REQ-019 WAIT_BUSY: counter counts cycles; tx_busy=1 -> WAIT_DONE; counter reaching START_TIMEOUT with tx_busy=0 -> err_timeout pulse, -> IDLE.
REQ-020 WAIT_DONE: tx_busy=0 -> IDLE; no other exit.
REQ-021 Latency: req sampled high in IDLE at edge k -> ack and START during cycle k+1, tx_start during cycle k+1, WAIT_BUSY from k+2.
REQ-022 Requester deasserts req or presents its next byte within 2 cycles after ack; req is ignored outside IDLE.
REQ-023 Simultaneous requests: exactly one ack per grant; all other requesters wait, none starved beyond N_REQ-1 grants.
REQ-024 req dropping between IDLE and grant edge is not possible (same-edge sample); a req dropping after ack has no effect.
REQ-025 Minimum one IDLE cycle between consecutive tx_start pulses.
REQ-026 ack, tx_start, err_timeout never high simultaneously with another pulse of the same signal on the next cycle.

Reset
REQ-027 reset=0 forces, asynchronously: state=IDLE, ack=0, tx_start=0, tx_data=8'h00, busy=0, err_timeout=0, counter=0, ptr=N_REQ-1, grant_id=0.
REQ-028 Reset mid-transmission aborts the sequence; after release the FSM waits in IDLE until tx_busy=0 before granting.
REQ-029 First grant after reset goes to the lowest-index active requester.

Structure
REQ-030 Package uart_arb_pkg holds state encoding constants, N_REQ and START_TIMEOUT defaults.
REQ-031 One sub-module uart_rr_pick: combinational round-robin picker (req, ptr -> valid, index).
REQ-032 uart_tx_arb connects directly to one uart2 instance's tx_start, tx_data, tx_busy; no other glue.

Verification
REQ-033 Single req[2]=1, req_data byte2=8'h41 -> ack[2] one cycle, tx_start one cycle later than grant edge, uart2 serialises 8'h41, busy low after tx_busy falls.
REQ-034 req=4'b1111 held, bytes 8'h10/11/12/13 -> grants 0,1,2,3,0 in order; each byte seen on uart2 tx_pin once per grant.
REQ-035 tx_busy tied 0 (no uart2) -> err_timeout pulses 16 cycles after WAIT_BUSY entry, FSM returns IDLE, next grant rotates.
REQ-036 reset=0 during WAIT_DONE with tx_busy=1 -> outputs at reset values immediately; after release no tx_start until tx_busy=0.
REQ-037 req[1] asserted while tx_busy=1 in IDLE -> no ack until tx_busy=0; then normal grant.
REQ-038 Loopback second uart2 rx on tx_pin -> received bytes match granted sequence in REQ-034 exactly.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart2 transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned N_REQ_DEF         = 4;
    localparam int unsigned START_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the search begins one slot after ptr and wraps around.
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] index
);

    localparam int unsigned PW = $clog2(N_REQ);

    always_comb begin
        int unsigned      w_pos;
        logic [PW-1:0]    w_idx;
        valid = 1'b0;
        index = '0;
        w_pos = 0;
        w_idx = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            w_pos = (32'(ptr) + off) % N_REQ;
            w_idx = w_pos[PW-1:0];
            if (!valid && req[w_idx]) begin
                valid = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding N_REQ byte requesters into one shared uart2 transmitter,
// with a timeout in case the transmitter never acknowledges a start pulse.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = N_REQ_DEF,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    arb_state_t    r_state;
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_valid;
    logic [PW-1:0] w_idx;

    uart_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .valid(w_valid),
        .index(w_idx)
    );

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
            r_cnt       <= '0;
            r_ptr       <= PW'(N_REQ - 1);
            grant_id    <= '0;
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // tx_start is set here so it is high exactly during the START cycle
                    if (w_valid && !tx_busy) begin
                        tx_data    <= req_data[{w_idx, 3'b000} +: 8];
                        ack[w_idx] <= 1'b1;
                        tx_start   <= 1'b1;
                        r_ptr      <= w_idx;
                        grant_id   <= w_idx;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb; the bench plays the uart2 transmitter by driving tx_busy.
module tb_uart_tx_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arb #(
        .N_REQ(4),
        .START_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_ack(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (ack == 4'b0 && cyc < max_cyc);
    endtask

    // Grant with one-cycle latency, then a transfer that holds tx_busy for busy_len cycles.
    task automatic grant_serve(input int exp_idx, input logic [7:0] exp_byte, input int busy_len);
        int cyc;
        wait_ack(20, cyc);
        check("grant_latency", cyc, 1);
        check("ack", ack, 32'(1) << exp_idx);
        check("tx_start", tx_start, 1);
        check("tx_data", tx_data, exp_byte);
        check("grant_id", grant_id, exp_idx);
        check("busy_start", busy, 1);
        step();
        check("ack_pulse", ack, 0);
        check("tx_start_pulse", tx_start, 0);
        tx_busy = 1'b1;
        repeat (busy_len) begin
            step();
            check("busy_hold", busy, 1);
            check("data_stable", tx_data, exp_byte);
        end
        tx_busy = 1'b0;
        step();
        check("busy_done", busy, 0);
    endtask

    initial begin
        int cyc;
        reset    = 1'b0;
        req      = 4'b0;
        req_data = 32'h13121110;
        tx_busy  = 1'b0;
        #3;
        check("rst_ack", ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_grant_id", grant_id, 0);

        // Single requester 2 with byte 0x41
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00410000;
        grant_serve(2, 8'h41, 5);
        req = 4'b0;
        step();
        check("idle_no_ack", ack, 0);

        // All four requesting: strict rotation from index 0
        do_reset();
        req      = 4'b1111;
        req_data = 32'h13121110;
        grant_serve(0, 8'h10, 3);
        grant_serve(1, 8'h11, 3);
        grant_serve(2, 8'h12, 3);
        grant_serve(3, 8'h13, 3);
        grant_serve(0, 8'h10, 3);
        req = 4'b0;

        // Transmitter never goes busy: timeout then rotation
        do_reset();
        req = 4'b0011;
        wait_ack(20, cyc);
        check("to_first_ack", ack, 4'b0001);
        check("to_first_gid", grant_id, 0);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!err_timeout && cyc < 40);
        check("timeout_cycles", cyc, 17);
        check("timeout_pulse", err_timeout, 1);
        check("timeout_idle", busy, 0);
        step();
        check("timeout_single", err_timeout, 0);
        check("to_rotate_ack", ack, 4'b0010);
        check("to_rotate_gid", grant_id, 1);
        check("to_rotate_start", tx_start, 1);
        req = 4'b0;

        // Asynchronous reset during WAIT_DONE
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00410000;
        wait_ack(20, cyc);
        check("ar_ack", ack, 4'b0100);
        step();
        tx_busy = 1'b1;
        step();
        check("ar_wait_done", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_ack0", ack, 0);
        check("ar_start0", tx_start, 0);
        check("ar_data0", tx_data, 0);
        check("ar_busy0", busy, 0);
        check("ar_err0", err_timeout, 0);
        check("ar_gid0", grant_id, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            step();
            check("ar_hold_start", tx_start, 0);
            check("ar_hold_ack", ack, 0);
        end
        tx_busy = 1'b0;
        step();
        check("ar_regrant_ack", ack, 4'b0100);
        check("ar_regrant_start", tx_start, 1);
        check("ar_regrant_data", tx_data, 8'h41);
        req = 4'b0;
        step();
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        step();
        check("ar_back_idle", busy, 0);

        // Request while transmitter still busy in IDLE
        tx_busy = 1'b1;
        req     = 4'b0010;
        repeat (4) begin
            step();
            check("bz_no_ack", ack, 0);
            check("bz_idle", busy, 0);
        end
        tx_busy = 1'b0;
        step();
        check("bz_ack", ack, 4'b0010);
        check("bz_gid", grant_id, 1);
        req = 4'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
